div_clk_checker: RTL and testbench

- Receiving end of the divided-clock path: samples a slow divided clock (e.g. a divide-by-4 output) as a data signal in the clk domain.
- Measures its high and low times in clk cycles and checks them against the expected ratio.
- Reports lock status, per-period errors and stuck-clock timeout.
- Sits beside clock-divider blocks as a self-check / bring-up monitor.

---
 rtl/div_clk_checker_pkg.sv | 25 ++
 rtl/div_clk_checker_edge_det.sv | 42 ++++
 rtl/div_clk_checker.sv | 166 ++++++++++++++++
 tb/tb_div_clk_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_checker_pkg.sv
// Shared types and ratio defaults for the divided-clock checker and the
// divider blocks it monitors.
`timescale 1ns/1ps
package div_clk_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Divide-by-4 ratio; the dividers pull the same constants so both ends agree.
  localparam int DEF_EXP_HIGH = 2;
  localparam int DEF_EXP_LOW  = 2;

  localparam int GOOD_W = 4;

  function automatic logic [GOOD_W-1:0] sat_inc_good(
    input logic [GOOD_W-1:0] val,
    input logic [GOOD_W-1:0] lim
  );
    return (val >= lim) ? lim : val + GOOD_W'(1);
  endfunction

endpackage

// File: rtl/div_clk_checker_edge_det.sv
// Two-stage sampler of a slow same-domain clock with rise/fall detection.
// Edges are suppressed until both history stages hold post-reset samples.
`timescale 1ns/1ps
module div_clk_checker_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic in_q;
  logic in_d;
  logic vld_p0_q;
  logic vld_p1_q;
  logic vld_p0_d;
  logic vld_p1_d;

  always_comb begin
    vld_p0_d = 1'b1;
    vld_p1_d = vld_p0_q;
  end

  // Stage boundary: raw sample -> in_q -> in_d, validity travels alongside.
  always_ff @(posedge clk) begin
    in_q <= sig_in;
    in_d <= in_q;
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign rise  = vld_p1_q &  in_q & ~in_d;
  assign fall  = vld_p1_q & ~in_q &  in_d;
  assign level = in_q;

endmodule

// File: rtl/div_clk_checker.sv
// Measures high/low times of a divided clock, flags ratio errors, tracks lock
// and detects a stuck clock.
`timescale 1ns/1ps
module div_clk_checker
  import div_clk_checker_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = DEF_EXP_HIGH,
  parameter int EXP_LOW  = DEF_EXP_LOW,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_vld,
  output logic             err,
  output logic             locked,
  output logic             stuck
);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  EXP_H_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  EXP_L_C   = CNT_W'(EXP_LOW);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);

  logic rise;
  logic fall;
  logic level;
  logic edge_w;
  logic rise_w;
  logic fall_w;
  logic timeout_w;
  logic good_w;
  logic [GOOD_W-1:0] good_inc_w;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CNT_W-1:0]  hlen_q,     hlen_d;
  logic [CNT_W-1:0]  high_len_q, high_len_d;
  logic [CNT_W-1:0]  low_len_q,  low_len_d;
  logic              meas_vld_q, meas_vld_d;
  logic              err_q,      err_d;
  logic              locked_q,   locked_d;
  logic              stuck_q,    stuck_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;

  div_clk_checker_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .sig_in (clk_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level)
  );

  // Direction of an edge is taken from the sampled level after the edge.
  assign edge_w     = rise | fall;
  assign rise_w     = edge_w &  level;
  assign fall_w     = edge_w & ~level;
  assign timeout_w  = (cnt_q == TIMEOUT_C) && !edge_w;
  assign good_w     = (hlen_q == EXP_H_C) && (cnt_q == EXP_L_C);
  assign good_inc_w = sat_inc_good(good_cnt_q, LOCK_C);

  always_comb begin
    if (edge_w) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    hlen_d     = hlen_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    meas_vld_d = 1'b0;
    err_d      = 1'b0;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    stuck_d    = stuck_q;

    if (timeout_w) begin
      state_d    = IDLE;
      good_cnt_d = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b1;
    end else begin
      if (rise_w) begin
        stuck_d = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rise_w) begin
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall_w) begin
            state_d = LOW;
            hlen_d  = cnt_q;
          end
        end
        LOW: begin
          if (rise_w) begin
            state_d    = HIGH;
            high_len_d = hlen_q;
            low_len_d  = cnt_q;
            meas_vld_d = 1'b1;
            if (good_w) begin
              good_cnt_d = good_inc_w;
              locked_d   = (good_inc_w == LOCK_C);
            end else begin
              good_cnt_d = '0;
              locked_d   = 1'b0;
              err_d      = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage boundary: all measurement state and outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hlen_q     <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      meas_vld_q <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hlen_q     <= hlen_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      meas_vld_q <= meas_vld_d;
      err_q      <= err_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      stuck_q    <= stuck_d;
    end
  end

  assign high_len = high_len_q;
  assign low_len  = low_len_q;
  assign meas_vld = meas_vld_q;
  assign err      = err_q;
  assign locked   = locked_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: lock, ratio errors, stuck clock, reset.
`timescale 1ns/1ps
module tb_div_clk_checker;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_in;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             meas_vld;
  logic             err;
  logic             locked;
  logic             stuck;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vld   = 0;

  always #5 clk = ~clk;

  div_clk_checker #(
    .CNT_W    (CNT_W),
    .EXP_HIGH (2),
    .EXP_LOW  (2),
    .LOCK_CNT (4),
    .TIMEOUT  (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (clk_in),
    .high_len (high_len),
    .low_len  (low_len),
    .meas_vld (meas_vld),
    .err      (err),
    .locked   (locked),
    .stuck    (stuck)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: inputs change on the falling edge, outputs read 1ns after rise.
  task automatic tick(input logic v, input logic r);
    @(negedge clk);
    clk_in = v;
    rst    = r;
    @(posedge clk);
    #1;
    if (meas_vld) n_vld++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    clk_in = 1'b0;

    repeat (3) tick(1'b0, 1'b1);
    chk("rst_meas_vld", meas_vld, 0);
    chk("rst_err",      err,      0);
    chk("rst_locked",   locked,   0);
    chk("rst_stuck",    stuck,    0);
    chk("rst_high_len", high_len, 0);
    chk("rst_low_len",  low_len,  0);

    // 2-high/2-low after two low cycles; report on the 2nd high sample of each later period.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 4; i++) begin
        tick(i < 2, 1'b0);
        if (i == 1) begin
          chk("t1_vld", meas_vld, int'(p >= 1));
          if (p >= 1) begin
            chk("t1_high_len", high_len, 2);
            chk("t1_low_len",  low_len,  2);
            chk("t1_err",      err,      0);
            chk("t1_locked",   locked,   int'(p >= 4));
          end
        end else begin
          chk("t1_vld_gap", meas_vld, 0);
        end
      end
    end

    // One 2-high/3-low period while locked.
    tick(1'b1, 1'b0);
    chk("t3_pre_vld", meas_vld, 0);
    tick(1'b1, 1'b0);
    chk("t3_pre_good_vld", meas_vld, 1);
    chk("t3_pre_locked",   locked,   1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) begin
        tick(i < 2, 1'b0);
        if (i == 1) begin
          chk("t3_vld",    meas_vld, 1);
          chk("t3_err",    err,      int'(p == 0));
          chk("t3_locked", locked,   int'(p == 4));
          if (p == 0) begin
            chk("t3_bad_high_len", high_len, 2);
            chk("t3_bad_low_len",  low_len,  3);
          end
        end
      end
    end

    // Hold high for 70 cycles while locked.
    for (int k = 1; k <= 70; k++) begin
      tick(1'b1, 1'b0);
      if (k == 2) begin
        chk("t4_last_vld",    meas_vld, 1);
        chk("t4_last_locked", locked,   1);
      end
      if (k == 65) begin
        chk("t4_stuck_before",  stuck,  0);
        chk("t4_locked_before", locked, 1);
      end
      if (k == 66) begin
        chk("t4_stuck_set",     stuck,  1);
        chk("t4_locked_clear",  locked, 0);
      end
    end
    chk("t4_stuck_hold", stuck, 1);
    n_vld = 0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t4_stuck_after_fall", stuck, 1);
    tick(1'b1, 1'b0);
    chk("t4_stuck_at_rise", stuck, 1);
    tick(1'b1, 1'b0);
    chk("t4_stuck_cleared", stuck, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("t4_no_early_vld", n_vld, 0);
    tick(1'b1, 1'b0);
    chk("t4_first_vld",  meas_vld, 1);
    chk("t4_high_len",   high_len, 2);
    chk("t4_low_len",    low_len,  2);
    chk("t4_err",        err,      0);
    chk("t4_locked",     locked,   0);

    // Relock (three more good periods), one extra, then reset mid-high.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        tick(i >= 2, 1'b0);
        if (i == 3) begin
          chk("t5_vld",    meas_vld, 1);
          chk("t5_locked", locked,   int'(p >= 2));
        end
      end
    end
    tick(1'b1, 1'b1);
    chk("t5_rst_locked",   locked,   0);
    chk("t5_rst_stuck",    stuck,    0);
    chk("t5_rst_vld",      meas_vld, 0);
    chk("t5_rst_err",      err,      0);
    chk("t5_rst_high_len", high_len, 0);
    chk("t5_rst_low_len",  low_len,  0);
    n_vld = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("t5_no_partial_vld", n_vld, 0);
    tick(1'b1, 1'b0);
    chk("t5_first_vld", meas_vld, 1);
    chk("t5_high_len",  high_len, 2);
    chk("t5_low_len",   low_len,  2);
    chk("t5_locked",    locked,   0);

    // 3-high/1-low from a fresh reset.
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 4; i++) begin
        tick(i < 3, 1'b0);
        if (i == 1) begin
          chk("t2_vld", meas_vld, int'(p >= 1));
          if (p >= 1) begin
            chk("t2_high_len", high_len, 3);
            chk("t2_low_len",  low_len,  1);
            chk("t2_err",      err,      1);
            chk("t2_locked",   locked,   0);
          end
        end else begin
          chk("t2_vld_gap", meas_vld, 0);
        end
      end
    end

    // clk_in held low from reset, then a single rise.
    repeat (2) tick(1'b0, 1'b1);
    n_vld = 0;
    for (int k = 1; k <= 70; k++) begin
      tick(1'b0, 1'b0);
      if (k == 64) chk("t6_stuck_before", stuck, 0);
      if (k == 65) chk("t6_stuck_set",    stuck, 1);
    end
    tick(1'b1, 1'b0);
    chk("t6_stuck_at_rise", stuck, 1);
    tick(1'b1, 1'b0);
    chk("t6_stuck_cleared", stuck, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_no_vld",  n_vld,  0);
    chk("t6_locked",  locked, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
